// File: rtl/pmem_pkg.sv
// rtl/pmem_pkg.sv - shared constants and types for the pmem burst adaptor
package pmem_pkg;

  localparam int LINE_W  = 256;
  localparam int BURST_W = 64;
  localparam int BEATS   = LINE_W / BURST_W;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } pmem_state_e;

  typedef logic [1:0] beat_idx_t;

  localparam beat_idx_t LAST_BEAT = beat_idx_t'(BEATS - 1);

endpackage

// File: rtl/pmem_burst_adaptor.sv
// rtl/pmem_burst_adaptor.sv - cache line to 4-beat memory burst adaptor
//
// Purpose: accepts whole-line read/write requests on the cache pmem_* side and
// completes them as BEATS-beat bursts of BURST_W bits on the mem_* side.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   pmem_address/read/write  line request from cache (held until pmem_resp)
//   pmem_wdata               line to write
//   pmem_rdata               last completed read line
//   pmem_resp                one-cycle completion pulse
//   mem_address/read/write   burst request toward memory (line-aligned address)
//   mem_wdata                current write beat
//   mem_rdata, mem_resp      read beat and per-beat handshake from memory
// Build option: PMEM_ADAPTOR_FAST_RESP_EN - completes in the last-beat cycle
// (combinational pmem_resp, beat-3 bypass onto pmem_rdata, no DONE state).
module pmem_burst_adaptor #(
  parameter int LINE_W  = pmem_pkg::LINE_W,
  parameter int BURST_W = pmem_pkg::BURST_W,
  parameter int ADDR_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pmem_address,
  input  logic               pmem_read,
  input  logic               pmem_write,
  input  logic [LINE_W-1:0]  pmem_wdata,
  output logic [LINE_W-1:0]  pmem_rdata,
  output logic               pmem_resp,
  output logic [ADDR_W-1:0]  mem_address,
  output logic               mem_read,
  output logic               mem_write,
  output logic [BURST_W-1:0] mem_wdata,
  input  logic [BURST_W-1:0] mem_rdata,
  input  logic               mem_resp
);
  import pmem_pkg::*;

  pmem_state_e       state;
  beat_idx_t         k;
  beat_idx_t         k_next;
  logic [LINE_W-1:0] line_q;   // write line latch, reused as read assembly buffer
  logic [LINE_W-1:0] rdata_q;
  logic [ADDR_W-1:0] line_addr;
  logic [LINE_W-1:0] read_line;
  logic              last_beat;
  logic              unused_addr_bits;

  assign line_addr        = {pmem_address[ADDR_W-1:5], 5'b0};
  assign unused_addr_bits = ^pmem_address[4:0];
  assign k_next           = k + 2'd1;
  assign last_beat        = mem_resp && (k == LAST_BEAT);
  // Final line = incoming last beat on top of the beats already assembled.
  assign read_line        = {mem_rdata, line_q[LINE_W-BURST_W-1:0]};

`ifdef PMEM_ADAPTOR_FAST_RESP_EN
  assign pmem_resp  = !rst && (state == READ || state == WRITE) && last_beat;
  assign pmem_rdata = (!rst && state == READ && last_beat) ? read_line : rdata_q;
`else
  logic resp_q;
  assign pmem_resp  = resp_q;
  assign pmem_rdata = rdata_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      k           <= '0;
      line_q      <= '0;
      rdata_q     <= '0;
      mem_address <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_wdata   <= '0;
`ifndef PMEM_ADAPTOR_FAST_RESP_EN
      resp_q      <= 1'b0;
`endif
    end else begin
`ifndef PMEM_ADAPTOR_FAST_RESP_EN
      resp_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          // Write has priority when both requests are presented.
          if (pmem_write) begin
            mem_address <= line_addr;
            line_q      <= pmem_wdata;
            mem_wdata   <= pmem_wdata[BURST_W-1:0];
            mem_write   <= 1'b1;
            k           <= '0;
            state       <= WRITE;
          end else if (pmem_read) begin
            mem_address <= line_addr;
            mem_read    <= 1'b1;
            k           <= '0;
            state       <= READ;
          end
        end
        READ: begin
          if (mem_resp) begin
            line_q[k*BURST_W +: BURST_W] <= mem_rdata;
            k <= k_next;
            if (last_beat) begin
              rdata_q  <= read_line;
              mem_read <= 1'b0;
`ifdef PMEM_ADAPTOR_FAST_RESP_EN
              state    <= IDLE;
`else
              resp_q   <= 1'b1;
              state    <= DONE;
`endif
            end
          end
        end
        WRITE: begin
          if (mem_resp) begin
            k         <= k_next;
            mem_wdata <= line_q[k_next*BURST_W +: BURST_W];
            if (last_beat) begin
              mem_write <= 1'b0;
`ifdef PMEM_ADAPTOR_FAST_RESP_EN
              state     <= IDLE;
`else
              resp_q    <= 1'b1;
              state     <= DONE;
`endif
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pmem_burst_adaptor.sv
// tb/tb_pmem_burst_adaptor.sv - randomized self-checking bench for pmem_burst_adaptor
module tb_pmem_burst_adaptor;

`ifdef PMEM_ADAPTOR_FAST_RESP_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  localparam int GAPFREE_LAT = FAST ? 4 : 5;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic [31:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [63:0]  mem_wdata;
  logic [63:0]  mem_rdata;
  logic         mem_resp;

  int n_tests = 0;
  int n_fail  = 0;
  logic [255:0] rdata_model;

  pmem_burst_adaptor dut (
    .clk(clk), .rst(rst),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [255:0] rand256();
    return {rand64(), rand64(), rand64(), rand64()};
  endfunction

  task automatic idle(input int n);
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    repeat (n) begin
      mem_resp  = ($urandom_range(0, 1) == 1);
      mem_rdata = rand64();
      @(negedge clk);
      check_eq("idle_pmem_resp", 256'(pmem_resp), 256'(0));
      check_eq("idle_mem_read", 256'(mem_read), 256'(0));
      check_eq("idle_mem_write", 256'(mem_write), 256'(0));
      check_eq("idle_pmem_rdata", pmem_rdata, rdata_model);
      @(posedge clk); #1;
    end
  endtask

  // Entered and left at posedge+1. gap_mode: 0 mem_resp always high,
  // 1 high on even cycles only, 2 random. abort_at: beats accepted before reset.
  task automatic run_txn(input bit is_wr, input bit both, input logic [31:0] addr,
                         input logic [255:0] data, input int gap_mode,
                         input int abort_at, input int exp_lat);
    logic [31:0]  exp_addr;
    logic [255:0] exp_rd;
    int  nb, last, cyc;
    bit  done, resp_drv, act, acc, exp_resp;
    exp_addr = {addr[31:5], 5'b0};
    nb = 0; last = -1; cyc = 0; done = 1'b0;
    pmem_read    = !is_wr || both;
    pmem_write   = is_wr;
    pmem_address = addr;
    pmem_wdata   = data;
    while (!done && cyc < 100) begin
      if (cyc > 0) begin
        pmem_address = $urandom;
        pmem_wdata   = rand256();
      end
      act = (cyc >= 1) && (nb < 4);
      case (gap_mode)
        0:       resp_drv = 1'b1;
        1:       resp_drv = (cyc % 2 == 0);
        default: resp_drv = ($urandom_range(0, 1) == 1);
      endcase
      mem_resp  = resp_drv;
      mem_rdata = (act && !is_wr) ? data[nb*64 +: 64] : rand64();
      @(negedge clk);
      check_eq("mem_read", 256'(mem_read), 256'(act && !is_wr));
      check_eq("mem_write", 256'(mem_write), 256'(act && is_wr));
      if (act) begin
        check_eq("mem_address", 256'(mem_address), 256'(exp_addr));
        if (is_wr) check_eq("mem_wdata", 256'(mem_wdata), 256'(data[nb*64 +: 64]));
      end
      acc = act && resp_drv;
      if (acc) begin
        nb++;
        if (nb == 4) last = cyc;
      end
      exp_resp = FAST ? (acc && nb == 4) : (last >= 0 && cyc == last + 1);
      exp_rd   = (!is_wr && last >= 0 && (FAST || cyc > last)) ? data : rdata_model;
      check_eq("pmem_resp", 256'(pmem_resp), 256'(exp_resp));
      check_eq("pmem_rdata", pmem_rdata, exp_rd);
      if (exp_resp) begin
        done = 1'b1;
        if (exp_lat >= 0) check_eq("latency", 256'(cyc), 256'(exp_lat));
        if (!is_wr) rdata_model = data;
      end
      if (abort_at >= 0 && acc && nb == abort_at) begin
        @(posedge clk); #1;
        rst = 1'b1; pmem_read = 1'b0; pmem_write = 1'b0; mem_resp = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; mem_resp = 1'b0;
        @(negedge clk);
        rdata_model = '0;
        check_eq("abort_pmem_resp", 256'(pmem_resp), 256'(0));
        check_eq("abort_mem_read", 256'(mem_read), 256'(0));
        check_eq("abort_mem_write", 256'(mem_write), 256'(0));
        check_eq("abort_mem_address", 256'(mem_address), 256'(0));
        check_eq("abort_mem_wdata", 256'(mem_wdata), 256'(0));
        check_eq("abort_pmem_rdata", pmem_rdata, 256'(0));
        @(posedge clk); #1;
        idle(3);
        return;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (!done) check_eq("timeout", 256'(1), 256'(0));
  endtask

  initial begin
    logic [255:0] line;
    rst = 1'b1; pmem_address = '0; pmem_read = 1'b0; pmem_write = 1'b0;
    pmem_wdata = '0; mem_rdata = '0; mem_resp = 1'b0;
    rdata_model = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_pmem_rdata", pmem_rdata, 256'(0));
    check_eq("rst_pmem_resp", 256'(pmem_resp), 256'(0));
    check_eq("rst_mem_address", 256'(mem_address), 256'(0));
    check_eq("rst_mem_read", 256'(mem_read), 256'(0));
    check_eq("rst_mem_write", 256'(mem_write), 256'(0));
    check_eq("rst_mem_wdata", 256'(mem_wdata), 256'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);

    line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    run_txn(1'b0, 1'b0, 32'h0000_1234, line, 0, -1, GAPFREE_LAT);
    idle(1);

    line = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
            64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    run_txn(1'b1, 1'b0, 32'h0000_8F40, line, 1, -1, -1);
    idle(1);

    run_txn(1'b1, 1'b1, $urandom, rand256(), 2, -1, -1);
    idle(1);

    run_txn(1'b0, 1'b0, $urandom, rand256(), 0, 3, -1);
    run_txn(1'b0, 1'b0, $urandom, rand256(), 0, -1, GAPFREE_LAT);

    run_txn(1'b0, 1'b0, $urandom, rand256(), 0, -1, GAPFREE_LAT);
    run_txn(1'b1, 1'b0, $urandom, rand256(), 0, -1, GAPFREE_LAT);
    idle(2);

    for (int i = 0; i < 40; i++) begin
      run_txn($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, $urandom,
              rand256(), int'($urandom_range(0, 2)), -1, -1);
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
